// File: rtl/dmem_if.sv
// Load/store port between the core and the data-memory responder, plus the
// bench's backdoor word-write channel.
interface dmem_if #(
  parameter int MEM_WIDTH  = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256
);
  localparam int AW = $clog2(DEPTH);

  logic                  mem_store_en;
  logic [1:0]            mem_store_type;
  logic [MEM_WIDTH-1:0]  mem_store_addr;
  logic [DATA_WIDTH-1:0] mem_store_value;
  logic                  mem_load_en;
  logic [1:0]            mem_load_type;
  logic [MEM_WIDTH-1:0]  mem_load_addr;
  logic [DATA_WIDTH-1:0] mem_load_value;
  logic                  mem_load_valid;
  logic                  init_we;
  logic [AW-1:0]         init_addr;
  logic [DATA_WIDTH-1:0] init_data;
  logic                  misalign_err;

  modport master (
    output mem_store_en, mem_store_type, mem_store_addr, mem_store_value,
    output mem_load_en, mem_load_type, mem_load_addr,
    output init_we, init_addr, init_data,
    input  mem_load_value, mem_load_valid, misalign_err
  );

  modport slave (
    input  mem_store_en, mem_store_type, mem_store_addr, mem_store_value,
    input  mem_load_en, mem_load_type, mem_load_addr,
    input  init_we, init_addr, init_data,
    output mem_load_value, mem_load_valid, misalign_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-lane memory with same-cycle store bypass and a
// fixed-latency load return pipeline. Array contents are not reset.

// One byte lane of storage; the store port bypasses onto the read port.
module dmem_lane #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          st_we,
  input  logic [AW-1:0] st_idx,
  input  logic [7:0]    st_byte,
  input  logic          init_we,
  input  logic [AW-1:0] init_idx,
  input  logic [7:0]    init_byte,
  input  logic [AW-1:0] rd_idx,
  output logic [7:0]    rd_byte
);
  logic [7:0] mem [DEPTH];

  // Store is written last so it overrides an init to the same entry.
  always_ff @(posedge clk) begin
    if (init_we) mem[init_idx] <= init_byte;
    if (st_we)   mem[st_idx]   <= st_byte;
  end

  assign rd_byte = (st_we && st_idx == rd_idx) ? st_byte : mem[rd_idx];
endmodule

module dmem_responder #(
  parameter int MEM_WIDTH    = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 256,
  parameter int LOAD_LATENCY = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  dmem_if.slave  bus
);
  localparam int AW        = $clog2(DEPTH);
  localparam int NUM_LANES = DATA_WIDTH / 8;

  typedef struct packed {
    logic                 bad;
    logic [AW-1:0]        idx;
    logic [1:0]           off;
    logic [NUM_LANES-1:0] mask;
  } dec_t;

  // Misaligned or reserved accesses get an empty lane mask.
  function automatic dec_t decode(input logic [1:0] typ, input logic [AW+1:0] addr);
    dec_t d;
    d.bad  = 1'b0;
    d.idx  = addr[AW+1:2];
    d.off  = addr[1:0];
    d.mask = '0;
    case (typ)
      2'b00: d.mask = NUM_LANES'(1) << addr[1:0];
      2'b01: begin
        d.bad  = addr[0];
        d.mask = addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        d.bad  = |addr[1:0];
        d.mask = '1;
      end
      default: d.bad = 1'b1;
    endcase
    if (d.bad) d.mask = '0;
    return d;
  endfunction

  dec_t sd, ld;
  assign sd = decode(bus.mem_store_type, bus.mem_store_addr[AW+1:0]);
  assign ld = decode(bus.mem_load_type,  bus.mem_load_addr[AW+1:0]);

  logic unused_hi_addr;
  assign unused_hi_addr = ^{bus.mem_store_addr[MEM_WIDTH-1:AW+2],
                            bus.mem_load_addr[MEM_WIDTH-1:AW+2]};

  logic [NUM_LANES-1:0][7:0] st_lanes, init_lanes, rd_lanes;
  logic [NUM_LANES-1:0]      st_we;
  logic                      init_ok;

  always_comb begin
    st_lanes = bus.mem_store_value;
    case (bus.mem_store_type)
      2'b00:   st_lanes = {NUM_LANES{bus.mem_store_value[7:0]}};
      2'b01:   st_lanes = {(NUM_LANES/2){bus.mem_store_value[15:0]}};
      default: st_lanes = bus.mem_store_value;
    endcase
  end

  assign st_we      = {NUM_LANES{bus.mem_store_en}} & sd.mask;
  assign init_lanes = bus.init_data;
  // A live store to the same word drops the whole backdoor write.
  assign init_ok    = bus.init_we &&
                      !(bus.mem_store_en && !sd.bad && sd.idx == bus.init_addr);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    dmem_lane #(.DEPTH(DEPTH), .AW(AW)) u_lane (
      .clk       (clk),
      .st_we     (st_we[g]),
      .st_idx    (sd.idx),
      .st_byte   (st_lanes[g]),
      .init_we   (init_ok),
      .init_idx  (bus.init_addr),
      .init_byte (init_lanes[g]),
      .rd_idx    (ld.idx),
      .rd_byte   (rd_lanes[g])
    );
  end

  logic [DATA_WIDTH-1:0] ld_word;

  always_comb begin
    ld_word = '0;
    if (bus.mem_load_en && !ld.bad) begin
      case (bus.mem_load_type)
        2'b00:   ld_word[7:0]  = rd_lanes[ld.off];
        2'b01:   ld_word[15:0] = {rd_lanes[{ld.off[1], 1'b1}], rd_lanes[{ld.off[1], 1'b0}]};
        2'b10:   ld_word       = rd_lanes;
        default: ld_word       = '0;
      endcase
    end
  end

  logic [LOAD_LATENCY:1]                 vld_pipe;
  logic [LOAD_LATENCY:1][DATA_WIDTH-1:0] dat_pipe;
  logic                                  err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
      err_q    <= 1'b0;
    end else begin
      vld_pipe[1] <= bus.mem_load_en;
      dat_pipe[1] <= ld_word;
      for (int i = 2; i <= LOAD_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
      err_q <= (bus.mem_store_en && sd.bad) || (bus.mem_load_en && ld.bad);
    end
  end

  assign bus.mem_load_valid = vld_pipe[LOAD_LATENCY];
  assign bus.mem_load_value = dat_pipe[LOAD_LATENCY];
  assign bus.misalign_err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: preload, byte/half/word access, bypass,
// back-to-back loads, misalignment, init/store collision and mid-flight reset.
module tb_dmem_responder;
  localparam int DEPTH = 256;

  logic clk, rst_n;
  int   n_chk, n_pass;

  dmem_if #(.MEM_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH)) bus ();

  dmem_responder #(.MEM_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH), .LOAD_LATENCY(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h exp %h", tag, got, exp);
  endtask

  task automatic idle();
    bus.mem_store_en = 1'b0; bus.mem_store_type = 2'b00;
    bus.mem_store_addr = '0; bus.mem_store_value = '0;
    bus.mem_load_en = 1'b0; bus.mem_load_type = 2'b00; bus.mem_load_addr = '0;
    bus.init_we = 1'b0; bus.init_addr = '0; bus.init_data = '0;
  endtask

  task automatic init_w(input int idx, input logic [31:0] d);
    @(negedge clk); idle();
    bus.init_we = 1'b1; bus.init_addr = 8'(idx); bus.init_data = d;
    @(negedge clk); idle();
  endtask

  task automatic store(input string tag, input logic [1:0] typ, input logic [31:0] addr,
                       input logic [31:0] val, input logic exp_err);
    @(negedge clk); idle();
    bus.mem_store_en = 1'b1; bus.mem_store_type = typ;
    bus.mem_store_addr = addr; bus.mem_store_value = val;
    @(posedge clk); #1;
    chk({tag, ".err"}, {31'b0, bus.misalign_err}, {31'b0, exp_err});
    @(negedge clk); idle();
  endtask

  task automatic load_chk(input string tag, input logic [1:0] typ, input logic [31:0] addr,
                          input logic [31:0] exp, input logic exp_err);
    @(negedge clk); idle();
    bus.mem_load_en = 1'b1; bus.mem_load_type = typ; bus.mem_load_addr = addr;
    @(posedge clk); #1;
    chk({tag, ".err"}, {31'b0, bus.misalign_err}, {31'b0, exp_err});
    chk({tag, ".early"}, {31'b0, bus.mem_load_valid}, 32'd0);
    @(negedge clk); idle();
    @(posedge clk); #1;
    chk({tag, ".vld"}, {31'b0, bus.mem_load_valid}, 32'd1);
    chk({tag, ".val"}, bus.mem_load_value, exp);
    @(posedge clk); #1;
    chk({tag, ".pulse"}, {31'b0, bus.mem_load_valid}, 32'd0);
  endtask

  logic [31:0] t4_exp [4];

  initial begin
    n_chk = 0; n_pass = 0;
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.vld", {31'b0, bus.mem_load_valid}, 32'd0);
    chk("rst.val", bus.mem_load_value, 32'd0);
    chk("rst.err", {31'b0, bus.misalign_err}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // preload and basic word load
    init_w(0, 32'h8899AABB);
    load_chk("t1", 2'b10, 32'h0, 32'h8899AABB, 1'b0);

    // byte store, then word/half/byte extraction
    store("t2.st", 2'b00, 32'h3, 32'h0000005A, 1'b0);
    load_chk("t2.w", 2'b10, 32'h0, 32'h5A99AABB, 1'b0);
    load_chk("t2.h", 2'b01, 32'h2, 32'h00005A99, 1'b0);
    load_chk("t2.b", 2'b00, 32'h1, 32'h000000AA, 1'b0);

    // same-cycle store bypass, later store must not leak into the load
    @(negedge clk); idle();
    bus.mem_store_en = 1'b1; bus.mem_store_type = 2'b10;
    bus.mem_store_addr = 32'h40; bus.mem_store_value = 32'hDEADBEEF;
    bus.mem_load_en = 1'b1; bus.mem_load_type = 2'b10; bus.mem_load_addr = 32'h40;
    @(posedge clk);
    @(negedge clk);
    bus.mem_load_en = 1'b0; bus.mem_store_value = 32'h0;
    @(posedge clk); #1;
    chk("t3.vld", {31'b0, bus.mem_load_valid}, 32'd1);
    chk("t3.val", bus.mem_load_value, 32'hDEADBEEF);
    @(negedge clk); idle();
    load_chk("t3.after", 2'b10, 32'h40, 32'h0, 1'b0);
    store("t3.hst", 2'b01, 32'h42, 32'h0000BEEF, 1'b0);
    load_chk("t3.hw", 2'b10, 32'h40, 32'hBEEF0000, 1'b0);
    load_chk("t3.hb", 2'b00, 32'h43, 32'h000000BE, 1'b0);

    // back-to-back loads
    t4_exp[0] = 32'h10203040; t4_exp[1] = 32'h50607080;
    t4_exp[2] = 32'h90A0B0C0; t4_exp[3] = 32'hD0E0F001;
    for (int i = 0; i < 4; i++) init_w(i, t4_exp[i]);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); idle();
      if (c < 4) begin
        bus.mem_load_en = 1'b1; bus.mem_load_type = 2'b10; bus.mem_load_addr = 32'(4 * c);
      end
      @(posedge clk); #1;
      if (c >= 1 && c <= 4) begin
        chk($sformatf("t4.vld%0d", c - 1), {31'b0, bus.mem_load_valid}, 32'd1);
        chk($sformatf("t4.val%0d", c - 1), bus.mem_load_value, t4_exp[c-1]);
      end else begin
        chk($sformatf("t4.idle%0d", c), {31'b0, bus.mem_load_valid}, 32'd0);
      end
    end

    // misaligned / reserved accesses
    store("t5.stw", 2'b10, 32'h2, 32'hFFFFFFFF, 1'b1);
    load_chk("t5.keep", 2'b10, 32'h0, 32'h10203040, 1'b0);
    store("t5.st11", 2'b11, 32'h0, 32'hFFFFFFFF, 1'b1);
    load_chk("t5.keep2", 2'b10, 32'h0, 32'h10203040, 1'b0);
    load_chk("t5.ldh", 2'b01, 32'h1, 32'h0, 1'b1);
    load_chk("t5.ld11", 2'b11, 32'h0, 32'h0, 1'b1);

    // init/store collision: store wins, init dropped; distinct words both land
    init_w(8, 32'h0);
    @(negedge clk); idle();
    bus.init_we = 1'b1; bus.init_addr = 8'd8; bus.init_data = 32'hFFFFFFFF;
    bus.mem_store_en = 1'b1; bus.mem_store_type = 2'b00;
    bus.mem_store_addr = 32'h20; bus.mem_store_value = 32'h000000AB;
    @(negedge clk); idle();
    bus.init_we = 1'b1; bus.init_addr = 8'd9; bus.init_data = 32'h12345678;
    bus.mem_store_en = 1'b1; bus.mem_store_type = 2'b10;
    bus.mem_store_addr = 32'h28; bus.mem_store_value = 32'h0BADCAFE;
    @(negedge clk); idle();
    load_chk("t7.coll", 2'b10, 32'h20, 32'h000000AB, 1'b0);
    load_chk("t7.init9", 2'b10, 32'h24, 32'h12345678, 1'b0);
    load_chk("t7.st10", 2'b10, 32'h28, 32'h0BADCAFE, 1'b0);

    // reset while loads are in flight
    init_w(5, 32'hCAFEF00D);
    @(negedge clk); idle();
    bus.mem_load_en = 1'b1; bus.mem_load_type = 2'b10; bus.mem_load_addr = 32'h14;
    @(posedge clk);
    @(negedge clk);
    bus.mem_load_addr = 32'h0;
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("t6.rst%0d", c), {31'b0, bus.mem_load_valid}, 32'd0);
    end
    @(negedge clk); idle(); rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("t6.rel%0d", c), {31'b0, bus.mem_load_valid}, 32'd0);
    end
    load_chk("t6.keep", 2'b10, 32'h14, 32'hCAFEF00D, 1'b0);
    load_chk("t6.alias", 2'b10, 32'(DEPTH * 4), 32'h10203040, 1'b0);
    load_chk("t6.alias5", 2'b10, 32'(DEPTH * 4 + 32'h14), 32'hCAFEF00D, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
